// File: rtl/spi_minion.sv
// spi_minion: SPI mode-0 peripheral endpoint. It oversamples cs/sclk/mosi in
// the clk domain. Each nbits-bit MOSI packet is deserialized into a val/rdy
// send message, and a buffered recv word is shifted out on MISO, MSB first.
module spi_minion #(
  parameter int unsigned nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(nbits + 2);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    XFER
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_cs_s1, r_cs_s2, r_cs_s3;
  logic             r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic             r_mosi_s1, r_mosi_s2, r_mosi_s3;

  logic [nbits-1:0] r_tx_buf;
  logic             r_tx_full;
  logic [nbits-1:0] r_tx_shift;
  logic [nbits-1:0] r_rx_shift;
  logic [CW-1:0]    r_bitcnt;

  logic             w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic             w_start, w_end, w_bit_in, w_bit_out, w_recv_fire;
  logic             w_send_fire, w_full_pkt;
  logic [nbits-1:0] w_tx_load;

  // Three-flop synchronizers for the asynchronous SPI pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_mosi_s3 <= 1'b0;
    end else begin
      r_cs_s1   <= cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_mosi_s3 <= r_mosi_s2;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= WAIT_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_IDLE: if (r_cs_s2)   w_state_nxt = IDLE;
      IDLE:      if (w_cs_fall) w_state_nxt = XFER;
      XFER:      if (w_cs_rise) w_state_nxt = IDLE;
      default:   w_state_nxt = WAIT_IDLE;
    endcase
  end

  // Edge detects and per-state action strobes; cs_rise masks same-cycle sclk edges
  always_comb begin
    w_cs_fall   = !r_cs_s2 && r_cs_s3;
    w_cs_rise   = r_cs_s2 && !r_cs_s3;
    w_sclk_rise = r_sclk_s2 && !r_sclk_s3;
    w_sclk_fall = !r_sclk_s2 && r_sclk_s3;
    w_start     = (r_state == IDLE) && w_cs_fall;
    w_end       = (r_state == XFER) && w_cs_rise;
    w_bit_in    = (r_state == XFER) && !w_cs_rise && w_sclk_rise;
    w_bit_out   = (r_state == XFER) && !w_cs_rise && w_sclk_fall;
    w_recv_fire = recv_val && !r_tx_full;
    w_send_fire = send_val && send_rdy;
    w_full_pkt  = (r_bitcnt == CW'(nbits));
    w_tx_load   = r_tx_full ? r_tx_buf : '0;
    recv_rdy    = !r_tx_full;
  end

  // TX buffer: accept a recv word when empty, release it at transaction start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_buf  <= '0;
      r_tx_full <= 1'b0;
    end else if (w_recv_fire) begin
      r_tx_buf  <= recv_msg;
      r_tx_full <= 1'b1;
    end else if (w_start) begin
      r_tx_full <= 1'b0;
    end
  end

  // Shift registers, bit counter and MISO driver
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bitcnt   <= '0;
      miso       <= 1'b0;
    end else begin
      if (w_start) begin
        r_bitcnt   <= '0;
        r_tx_shift <= w_tx_load;
        miso       <= w_tx_load[nbits-1];
      end
      if (w_end) miso <= 1'b0;
      if (w_bit_in) begin
        r_rx_shift <= {r_rx_shift[nbits-2:0], r_mosi_s2};
        if (r_bitcnt != CW'(nbits + 1)) r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_bit_out) begin
        r_tx_shift <= {r_tx_shift[nbits-2:0], 1'b0};
        miso       <= r_tx_shift[nbits-2];
      end
    end
  end

  // Send channel and sticky overflow; the drop decision uses the pre-handshake send_val
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      send_val <= 1'b0;
      send_msg <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_send_fire) send_val <= 1'b0;
      if (w_end && w_full_pkt) begin
        if (!send_val) begin
          send_val <= 1'b1;
          send_msg <= r_rx_shift;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_minion.sv
// Testbench for spi_minion: drives a mode-0 SPI master and the val/rdy ports,
// and checks both directions against a word-level reference model.
module tb_spi_minion;

  localparam int unsigned NB   = 32;
  localparam int unsigned HALF = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs, sclk, mosi, miso;
  logic          recv_val, recv_rdy;
  logic [NB-1:0] recv_msg;
  logic          send_val, send_rdy;
  logic [NB-1:0] send_msg;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] rx_q[$];

  spi_minion #(.nbits(NB)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Record every completed send handshake
  always @(negedge clk) begin
    if (!reset && send_val && send_rdy) rx_q.push_back(send_msg);
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    cs   = 1'b1;
    mosi = 1'b0;
    tick(2 * HALF);
  endtask

  // Clocks nb bits of word out MSB first; returns MISO sampled at each sclk rise
  task automatic clock_bits(input int unsigned nb, input logic [63:0] word,
                            output logic [63:0] mb);
    mb = '0;
    for (int i = int'(nb) - 1; i >= 0; i--) begin
      mosi = word[i];
      tick(HALF);
      sclk = 1'b1;
      mb   = {mb[62:0], miso};
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input int unsigned nb, input logic [63:0] word,
                      output logic [63:0] mb, output logic rdy_mid);
    cs_low();
    rdy_mid = recv_rdy;
    clock_bits(nb, word, mb);
    tick(HALF);
    cs_high();
  endtask

  task automatic load_tx(input logic [NB-1:0] w);
    int unsigned n;
    n = 0;
    while (!recv_rdy && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (!recv_rdy) begin
      errors++;
      $display("FAIL load_tx_timeout: recv_rdy=%0b required 1", recv_rdy);
    end
    recv_msg = w;
    recv_val = 1'b1;
    tick(1);
    recv_val = 1'b0;
    checks++;
    if (recv_rdy !== 1'b0) begin
      errors++;
      $display("FAIL recv_rdy_after_load: got %0b required 0", recv_rdy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({miso, send_val, overflow, recv_rdy} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ctrl: miso/send_val/overflow/recv_rdy got %b required 0001",
               {miso, send_val, overflow, recv_rdy});
    end
    checks++;
    if (send_msg !== '0) begin
      errors++;
      $display("FAIL reset_msg: got %h required 0", send_msg);
    end
  endtask

  task automatic test_basic();
    logic [63:0] mb;
    logic        rm;
    rx_q.delete();
    xfer(NB, 64'hDEADBEEF, mb, rm);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_rx: got %0d pkts first %h required 1 pkt deadbeef",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'h0);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_overflow: got %0b required 0", overflow);
    end
  endtask

  task automatic test_full_duplex();
    logic [63:0] mb;
    logic        rm;
    rx_q.delete();
    load_tx(32'hA5A50F0F);
    xfer(NB, 64'h12345678, mb, rm);
    checks++;
    if (mb[31:0] !== 32'hA5A50F0F) begin
      errors++;
      $display("FAIL duplex_miso: got %h required a5a50f0f", mb[31:0]);
    end
    checks++;
    if (rm !== 1'b1) begin
      errors++;
      $display("FAIL duplex_rdy_after_csfall: got %0b required 1", rm);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL duplex_rx: got %0d pkts first %h required 1 pkt 12345678",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'h0);
    end
  endtask

  task automatic test_empty_tx();
    logic [63:0] mb;
    logic        rm;
    logic [31:0] d;
    rx_q.delete();
    d = $urandom;
    xfer(NB, {32'h0, d}, mb, rm);
    checks++;
    if (mb[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL empty_miso: got %h required 00000000", mb[31:0]);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== d) begin
      errors++;
      $display("FAIL empty_rx: got %0d pkts required 1 pkt %h", rx_q.size(), d);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] mb;
    logic        rm;
    rx_q.delete();
    send_rdy = 1'b0;
    xfer(NB, 64'h1, mb, rm);
    xfer(NB, 64'h2, mb, rm);
    checks++;
    if (send_val !== 1'b1 || send_msg !== 32'h1) begin
      errors++;
      $display("FAIL bp_hold: send_val=%0b msg=%h required 1 00000001", send_val, send_msg);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: got %0b required 1", overflow);
    end
    send_rdy = 1'b1;
    tick(2);
    checks++;
    if (send_val !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: send_val=%0b overflow=%0b required 0 1", send_val, overflow);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'h1) begin
      errors++;
      $display("FAIL bp_delivered: got %0d pkts required 1 pkt 00000001", rx_q.size());
    end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_overflow_reset: got %0b required 0", overflow);
    end
  endtask

  task automatic test_malformed();
    logic [63:0] mb;
    logic        rm;
    rx_q.delete();
    xfer(31, 64'h7FFF_FFFF, mb, rm);
    xfer(33, 64'h1_2345_6789, mb, rm);
    checks++;
    if (rx_q.size() != 0 || send_val !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL malformed_drop: pkts=%0d send_val=%0b overflow=%0b required 0 0 0",
               rx_q.size(), send_val, overflow);
    end
    xfer(NB, 64'hCAFEF00D, mb, rm);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL malformed_recover: got %0d pkts required 1 pkt cafef00d", rx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] mb;
    logic [63:0] mb2;
    logic        rm;
    logic        bad;
    rx_q.delete();
    cs_low();
    clock_bits(10, 64'h2AB, mb);
    reset = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (miso !== 1'b0 || send_val !== 1'b0) bad = 1'b1;
    end
    reset = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rstmid_during_reset: miso=%0b send_val=%0b required 0 0", miso, send_val);
    end
    clock_bits(22, 64'h3F_FFFF, mb2);
    tick(HALF);
    cs_high();
    checks++;
    if (mb2[21:0] !== 22'h0) begin
      errors++;
      $display("FAIL rstmid_miso: got %h required 0", mb2[21:0]);
    end
    checks++;
    if (rx_q.size() != 0 || send_val !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nopkt: pkts=%0d send_val=%0b overflow=%0b required 0 0 0",
               rx_q.size(), send_val, overflow);
    end
    xfer(NB, 64'h0BADC0DE, mb, rm);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'h0BADC0DE) begin
      errors++;
      $display("FAIL rstmid_recover: got %0d pkts required 1 pkt 0badc0de", rx_q.size());
    end
  endtask

  // Random full-duplex traffic: model says MISO carries the preloaded word
  // (or zeros when none) and every 32-bit MOSI word is delivered in order
  task automatic test_random();
    logic [63:0]   mb;
    logic          rm;
    logic [NB-1:0] exp_rx[$];
    logic [NB-1:0] d, t, exp_miso;
    rx_q.delete();
    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      t = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        load_tx(t);
        exp_miso = t;
      end else begin
        exp_miso = '0;
      end
      exp_rx.push_back(d);
      xfer(NB, {32'h0, d}, mb, rm);
      checks++;
      if (mb[31:0] !== exp_miso) begin
        errors++;
        $display("FAIL rand_miso[%0d]: got %h required %h", k, mb[31:0], exp_miso);
      end
    end
    checks++;
    if (rx_q.size() != exp_rx.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d pkts required %0d", rx_q.size(), exp_rx.size());
    end else begin
      for (int k = 0; k < exp_rx.size(); k++) begin
        checks++;
        if (rx_q[k] !== exp_rx[k]) begin
          errors++;
          $display("FAIL rand_rx[%0d]: got %h required %h", k, rx_q[k], exp_rx[k]);
        end
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL rand_overflow: got %0b required 0", overflow);
    end
  endtask

  initial begin
    reset    = 1'b0;
    cs       = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_full_duplex();
    test_empty_tx();
    test_backpressure();
    test_malformed();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
